// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye security-device bus master:
// state encoding, default strobe hold and the latched command record.
package jtpopeye_pkg;

    localparam int ACC_TICKS_DEF = 2;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PUSH_A   = 3'd1;
    localparam logic [2:0] ST_PUSH_B   = 3'd2;
    localparam logic [2:0] ST_WR_SHIFT = 3'd3;
    localparam logic [2:0] ST_RD_WAIT  = 3'd4;
    localparam logic [2:0] ST_RD_CAP   = 3'd5;
    localparam logic [2:0] ST_GAP      = 3'd6;

    typedef struct packed {
        logic [1:0] push;
        logic [7:0] data_a;
        logic [7:0] data_b;
        logic [2:0] shift;
    } sec_cmd_t;

    // A push count of 3 behaves as 2.
    function automatic logic [1:0] clamp_push(input logic [1:0] p);
        return (p == 2'd3) ? 2'd2 : p;
    endfunction

endpackage

// File: rtl/jtpopeye_sec_strobe.sv
// Cen-gated down-counter timing how long each bus phase is held.
// zero_o is high on the final tick of a phase loaded with length len_i.
module jtpopeye_sec_strobe (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen_i,
    input  logic       load_i,
    input  logic [3:0] len_i,
    output logic       zero_o
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // next count: reload on phase entry, otherwise count down to zero and stay
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = len_i - 4'd1;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else if (cen_i) begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/jtpopeye_sec_master.sv
// Bus master for the Popeye security device: pushes up to two data bytes,
// writes the shift amount, then reads back the shifted result byte.
module jtpopeye_sec_master
    import jtpopeye_pkg::*;
#(
    parameter int ACC_TICKS = ACC_TICKS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cen,
    input  logic       req,
    input  logic [1:0] push,
    input  logic [7:0] data_a,
    input  logic [7:0] data_b,
    input  logic [2:0] shift,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       sec_cs,
    output logic       sec_a0,
    output logic       sec_wr_n,
    output logic       sec_rd_n,
    output logic [7:0] sec_dout,
    input  logic [7:0] sec_din
);

    logic [2:0] st_q, st_d;
    logic [2:0] gap_nxt_q, gap_nxt_d;
    sec_cmd_t   cmd_q, cmd_d;
    logic [7:0] result_q, result_d;
    logic       busy_q, done_q;
    logic       cs_q, cs_d, a0_q, a0_d, wr_q, wr_d, rd_q, rd_d;
    logic [7:0] dout_q, dout_d;
    logic       accept_s, load_s, zero_s;
    logic [3:0] len_s;

    assign accept_s = (st_q == ST_IDLE) && req;

    // command capture on acceptance
    always_comb begin
        cmd_d = cmd_q;
        if (accept_s) begin
            cmd_d.push   = clamp_push(push);
            cmd_d.data_a = data_a;
            cmd_d.data_b = data_b;
            cmd_d.shift  = shift;
        end else begin
            cmd_d = cmd_q;
        end
    end

    // sequencing; every write phase returns through GAP, which remembers its successor
    always_comb begin
        st_d      = st_q;
        gap_nxt_d = gap_nxt_q;
        result_d  = result_q;
        case (st_q)
            ST_IDLE: begin
                if (accept_s) begin
                    st_d = (cmd_d.push != 2'd0) ? ST_PUSH_A : ST_WR_SHIFT;
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_PUSH_A: begin
                if (zero_s) begin
                    st_d      = ST_GAP;
                    gap_nxt_d = (cmd_q.push == 2'd2) ? ST_PUSH_B : ST_WR_SHIFT;
                end else begin
                    st_d = ST_PUSH_A;
                end
            end
            ST_PUSH_B: begin
                if (zero_s) begin
                    st_d      = ST_GAP;
                    gap_nxt_d = ST_WR_SHIFT;
                end else begin
                    st_d = ST_PUSH_B;
                end
            end
            ST_WR_SHIFT: begin
                if (zero_s) begin
                    st_d      = ST_GAP;
                    gap_nxt_d = ST_RD_WAIT;
                end else begin
                    st_d = ST_WR_SHIFT;
                end
            end
            ST_GAP:    st_d = gap_nxt_q;
            ST_RD_WAIT: begin
                if (zero_s) begin
                    st_d     = ST_RD_CAP;
                    result_d = sec_din;
                end else begin
                    st_d = ST_RD_WAIT;
                end
            end
            ST_RD_CAP: st_d = ST_IDLE;
            default:   st_d = ST_IDLE;
        endcase
    end

    // bus decode for the state being entered, so the pins are registered
    always_comb begin
        cs_d   = 1'b1;
        a0_d   = a0_q;
        wr_d   = 1'b1;
        rd_d   = 1'b1;
        dout_d = dout_q;
        case (st_d)
            ST_PUSH_A:   begin cs_d = 1'b0; a0_d = 1'b1; wr_d = 1'b0; dout_d = cmd_d.data_a; end
            ST_PUSH_B:   begin cs_d = 1'b0; a0_d = 1'b1; wr_d = 1'b0; dout_d = cmd_d.data_b; end
            ST_WR_SHIFT: begin cs_d = 1'b0; a0_d = 1'b0; wr_d = 1'b0; dout_d = {5'b0, cmd_d.shift}; end
            ST_RD_WAIT:  begin cs_d = 1'b0; a0_d = 1'b0; rd_d = 1'b0; end
            default:     begin cs_d = 1'b1; wr_d = 1'b1; rd_d = 1'b1; end
        endcase
    end

    // read phase is one tick longer to cover the device output register
    assign load_s = (st_d != st_q);
    assign len_s  = (st_d == ST_RD_WAIT) ? 4'(ACC_TICKS + 1) : 4'(ACC_TICKS);

    jtpopeye_sec_strobe u_strobe (
        .clk    (clk),
        .rst_n  (rst_n),
        .cen_i  (cen),
        .load_i (load_s),
        .len_i  (len_s),
        .zero_o (zero_s)
    );

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= ST_IDLE;
            gap_nxt_q <= ST_IDLE;
            cmd_q     <= '0;
            result_q  <= 8'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_q      <= 1'b1;
            a0_q      <= 1'b1;
            wr_q      <= 1'b1;
            rd_q      <= 1'b1;
            dout_q    <= 8'd0;
        end else if (cen) begin
            st_q      <= st_d;
            gap_nxt_q <= gap_nxt_d;
            cmd_q     <= cmd_d;
            result_q  <= result_d;
            busy_q    <= (st_d != ST_IDLE);
            done_q    <= (st_d == ST_RD_CAP);
            cs_q      <= cs_d;
            a0_q      <= a0_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            dout_q    <= dout_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign sec_cs   = cs_q;
    assign sec_a0   = a0_q;
    assign sec_wr_n = wr_q;
    assign sec_rd_n = rd_q;
    assign sec_dout = dout_q;

endmodule
